// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock, with a start/busy/done handshake.
// Optional SUB_OVERFLOW_EN adds output V (signed overflow), registered with Diff/Bout.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
`ifdef SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
`endif

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_acc_next;

  assign w_a        = r_a[0];
  assign w_b        = r_b[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_acc_next = {w_d, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      V       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving WIDTH+1 cycle throughput.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SUB_OVERFLOW_EN
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
`endif
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            Diff    <= w_acc_next;
            Bout    <= w_br_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
`ifdef SUB_OVERFLOW_EN
            V       <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=16; V is checked when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0]  a4 = '0, b4 = '0, diff4;
  logic        s16 = 1'b0, bin16 = 1'b0, busy16, done16, bout16;
  logic [15:0] a16 = '0, b16 = '0, diff16;
`ifdef SUB_OVERFLOW_EN
  logic        v4, v16;
`endif

  int checks = 0;
  int errors = 0;

  // Expected entries are {V, Bout, Diff}.
  logic [5:0]  q4[$];
  logic [17:0] q16[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4)
`ifdef SUB_OVERFLOW_EN
    , .V(v4)
`endif
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .A(a16), .B(b16), .Bin(bin16),
    .busy(busy16), .done(done16), .Diff(diff16), .Bout(bout16)
`ifdef SUB_OVERFLOW_EN
    , .V(v16)
`endif
  );

  function automatic logic [5:0] m4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] f;
    f = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    return {(a[3] != b[3]) && (f[3] != a[3]), f[4], f[3:0]};
  endfunction

  function automatic logic [17:0] m16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] f;
    f = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    return {(a[15] != b[15]) && (f[15] != a[15]), f[16], f[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_done4();
    logic seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk("done4_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_done16();
    logic seen = 1'b0;
    for (int k = 0; k < 24 && !seen; k++) begin
      @(negedge clk);
      if (done16) seen = 1'b1;
    end
    chk("done16_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin, input logic [5:0] e);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; s4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    wait_done4();
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bin; s16 = 1'b1;
    q16.push_back(m16(a, b, bin));
    @(negedge clk);
    s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    wait_done16();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (done4) begin
          logic [5:0] e;
          if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb4_unexpected_done: got Diff=%0h Bout=%0b, expected no result", diff4, bout4);
          end else begin
            e = q4.pop_front();
`ifdef SUB_OVERFLOW_EN
            chk("sb4_result", {26'b0, v4, bout4, diff4}, {26'b0, e});
`else
            chk("sb4_result", {27'b0, bout4, diff4}, {27'b0, e[4:0]});
`endif
          end
        end
        if (done16) begin
          logic [17:0] e;
          if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb16_unexpected_done: got Diff=%0h Bout=%0b, expected no result", diff16, bout16);
          end else begin
            e = q16.pop_front();
`ifdef SUB_OVERFLOW_EN
            chk("sb16_result", {14'b0, v16, bout16, diff16}, {14'b0, e});
`else
            chk("sb16_result", {15'b0, bout16, diff16}, {15'b0, e[16:0]});
`endif
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset4", {25'b0, busy4, done4, bout4, diff4}, 32'd0);
    chk("reset16", {13'b0, busy16, done16, bout16, diff16}, 32'd0);
    rst_n = 1'b1;

    // 9 - 3 with exact handshake timing
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; s4 = 1'b1;
    q4.push_back({1'b1, 1'b0, 4'h6});
    @(negedge clk);
    s4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_busy_done_mid", {30'b0, busy4, done4}, 32'b10);
    end
    @(negedge clk);
    chk("t1_busy_done_end", {30'b0, busy4, done4}, 32'b01);

    run4(4'd3, 4'd9, 1'b0, {1'b1, 1'b1, 4'hA});
    run4(4'd0, 4'd0, 1'b1, {1'b0, 1'b1, 4'hF});
    run4(4'd5, 4'd5, 1'b0, {1'b0, 1'b0, 4'h0});
    run4(4'd8, 4'd1, 1'b0, {1'b1, 1'b0, 4'h7});
    run4(4'd7, 4'hF, 1'b0, {1'b1, 1'b1, 4'h8});
    run4(4'd6, 4'd2, 1'b0, {1'b0, 1'b0, 4'h4});

    // Start during SHIFT ignored; start held in DONE chains the next op
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; s4 = 1'b1;
    q4.push_back({1'b0, 1'b0, 4'h5});
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; bin4 = 1'b1; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    chk("t3_no_early_done", {31'b0, done4}, 32'd0);
    @(negedge clk);
    chk("t3_done", {31'b0, done4}, 32'd1);
    a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; s4 = 1'b1;
    q4.push_back({1'b1, 1'b0, 4'h7});
    @(negedge clk);
    s4 = 1'b0;
    chk("t3_held_result", {27'b0, bout4, diff4}, {27'b0, 1'b0, 4'h5});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_chain_wait", {30'b0, busy4, done4}, 32'b10);
    end
    @(negedge clk);
    chk("t3_chain_done", {31'b0, done4}, 32'd1);

    // Reset mid-SHIFT aborts
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
`ifdef SUB_OVERFLOW_EN
    chk("abort_clear_v", {31'b0, v4}, 32'd0);
`endif
    chk("abort_clear", {25'b0, busy4, done4, bout4, diff4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done4}, 32'd0);
    end

    // Exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run4(v[3:0], v[7:4], v[8], m4(v[3:0], v[7:4], v[8]));
    end

    // WIDTH=16 edge cases and random vectors
    run16(16'h0000, 16'h0000, 1'b1);
    run16(16'h8000, 16'h0001, 1'b0);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q4.size() + q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
